// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; DEPTH need not be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic                    do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage: PC owner, pipelined imem requests, prefetch queue toward Decode.
// FETCH_BYPASS_EN: forward a response straight to Decode when the queue is empty.
module fetch_prefetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUTS = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_inst
);

  localparam int QCW = cnt_w(DEPTH);
  localparam int OW  = cnt_w(MAX_OUTS);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [OW-1:0]   outs_q, drop_q;

  entry_t          q_din, q_dout, rsp, head;
  logic            q_push, q_pop, q_full, q_empty;
  logic [QCW-1:0]  q_count;

  logic [XLEN-1:0] t_dout;
  logic            t_push, t_pop, t_full, t_empty;
  logic [OW-1:0]   t_count;

  logic [31:0]     q_fill, credit;
  logic            issue, rsp_take, rsp_drop, byp;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^i_redirect_pc[1:0];

  // Queue slots are reserved at issue time, so a response can always be pushed.
  assign q_fill = 32'(q_count) + 32'(outs_q);
  assign credit = 32'(outs_q) + 32'(drop_q);

  assign o_imem_req  = !i_reset && !i_redirect &&
                       (q_fill < 32'(DEPTH)) && (credit < 32'(MAX_OUTS));
  assign o_imem_addr = pc_q;
  assign issue       = o_imem_req && i_imem_gnt;

  assign rsp_drop = i_imem_rvalid && (drop_q != '0);
  assign rsp_take = i_imem_rvalid && (drop_q == '0);
  assign rsp      = '{pc: t_dout, inst: i_imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign byp = q_empty && rsp_take && !i_redirect && !i_reset;
`else
  assign byp = 1'b0;
`endif

  assign head       = q_empty ? rsp : q_dout;
  assign o_id_valid = !i_reset && (!q_empty || byp);
  assign o_id_pc    = o_id_valid ? head.pc : '0;
  assign o_id_inst  = o_id_valid ? head.inst : XLEN'(NOP_INST);

  // A bypassed response consumed by Decode never touches the queue.
  assign q_din  = rsp;
  assign q_push = rsp_take && !i_redirect && !(byp && i_id_ready);
  assign q_pop  = !q_empty && i_id_ready && !i_redirect && !i_reset;

  assign t_push = issue;
  assign t_pop  = rsp_take;

  fetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_entry_q (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .flush   (i_redirect),
    .push    (q_push),
    .din     (q_din),
    .pop     (q_pop),
    .dout    (q_dout),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTS)) u_tag_q (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .flush   (i_redirect),
    .push    (t_push),
    .din     (pc_q),
    .pop     (t_pop),
    .dout    (t_dout),
    .full    (t_full),
    .empty   (t_empty),
    .count   (t_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q   <= RESET_PC;
      outs_q <= '0;
      drop_q <= '0;
    end else if (i_redirect) begin
      // Everything still in flight becomes drop credit, minus a response landing now.
      pc_q   <= {i_redirect_pc[XLEN-1:2], 2'b00};
      drop_q <= drop_q + outs_q - OW'(i_imem_rvalid);
      outs_q <= '0;
    end else begin
      if (issue) pc_q <= pc_q + XLEN'(4);
      outs_q <= outs_q + OW'(issue) - OW'(rsp_take);
      drop_q <= drop_q - OW'(rsp_drop);
    end
  end

  // Protocol and bookkeeping invariants.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (i_imem_rvalid) assert (credit != '0);
      assert (t_count == outs_q);
      assert (!(q_push && q_full && !q_pop));
      assert (!(t_push && t_full));
      assert (!(rsp_take && t_empty));
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed bench for fetch_prefetch_stage with an in-order imem model and scoreboard.
module tb_fetch_prefetch_stage;
  import fetch_pkg::*;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_OUTS = 2;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic            clk;
  logic            i_reset, i_redirect, i_imem_gnt, i_imem_rvalid, i_id_ready;
  logic [XLEN-1:0] i_redirect_pc, i_imem_rdata;
  logic            o_imem_req, o_id_valid;
  logic [XLEN-1:0] o_imem_addr, o_id_pc, o_id_inst;

  fetch_prefetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS), .RESET_PC('0)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_id_valid    (o_id_valid),
    .i_id_ready    (i_id_ready),
    .o_id_pc       (o_id_pc),
    .o_id_inst     (o_id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        pend[$];
  fetch_entry_t exp_q[$];

  int n_cmp, n_err, cyc, s_cyc, lat, gnt_mode, n_dlv, r_cyc, v_cyc;
  logic        s_req, s_rvalid, s_valid, acc_now, dlv_now;
  logic [31:0] s_addr, s_pc, s_inst, last_acc, dlv_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle, update memory model/scoreboard, drive next inputs.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    s_cyc    = cyc;
    s_req    = o_imem_req;
    s_addr   = o_imem_addr;
    s_rvalid = i_imem_rvalid;
    s_valid  = o_id_valid;
    s_pc     = o_id_pc;
    s_inst   = o_id_inst;
    acc_now  = o_imem_req && i_imem_gnt;
    dlv_now  = 1'b0;
    if (!i_reset) begin
      if (!s_valid) chk("idle_inst_nop", s_inst, NOP_INST);
      if (i_redirect) begin
        exp_q.delete();
      end else if (s_valid && i_id_ready) begin
        dlv_now = 1'b1;
        dlv_pc  = s_pc;
        n_dlv++;
        chk("delivery_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("id_pc", s_pc, e.pc);
          chk("id_inst", s_inst, e.inst);
        end
      end
      if (acc_now) begin
        exp_q.push_back('{pc: s_addr, inst: mem_word(s_addr)});
        pend.push_back('{addr: s_addr, due: cyc + lat});
        last_acc = s_addr;
      end
      if (s_rvalid) void'(pend.pop_front());
      chk("outstanding_bound", 32'(pend.size() <= MAX_OUTS), 32'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
    i_imem_gnt = (gnt_mode == 0) || (gnt_mode == 1 && (cyc % 2) == 0);
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(pend[0].addr);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    i_reset       = 1'b1;
    i_redirect    = 1'b0;
    i_imem_rvalid = 1'b0;
    pend.delete();
    exp_q.delete();
    repeat (3) tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_pc", s_pc, 32'd0);
    chk("rst_inst", s_inst, NOP_INST);
    i_reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; n_dlv = 0; lat = 1; gnt_mode = 0;
    i_reset = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_id_ready = 1'b1;
    last_acc = '0; dlv_pc = '0;

    // 1: streaming with 1-cycle memory
    do_reset();
    tick();
    chk("t1_first_req", 32'(s_req), 32'd1);
    chk("t1_first_addr", s_addr, 32'h0);
    r_cyc = -1; v_cyc = -1; n_dlv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rvalid && r_cyc < 0) r_cyc = s_cyc;
      if (s_valid && v_cyc < 0) v_cyc = s_cyc;
    end
    chk("t1_rsp_to_valid", 32'(v_cyc - r_cyc), BYP ? 32'd0 : 32'd1);
    chk("t1_throughput", 32'(n_dlv >= 16), 32'd1);

    // 2: decode stall fills the queue, then drains in order (also a mid-run reset)
    i_id_ready = 1'b0;
    do_reset();
    tick();
    chk("t2_valid_cleared", 32'(s_valid), 32'd0);
    chk("t2_addr_after_reset", s_addr, 32'h0);
    repeat (10) tick();
    chk("t2_buffered", 32'(exp_q.size()), 32'(DEPTH));
    chk("t2_req_blocked", 32'(s_req), 32'd0);
    chk("t2_valid_held", 32'(s_valid), 32'd1);
    chk("t2_head_pc", s_pc, 32'h0);
    i_id_ready = 1'b1;
    n_dlv = 0;
    repeat (8) tick();
    chk("t2_drained", 32'(n_dlv >= DEPTH), 32'd1);

    // 3: redirect with 0x10 and 0x14 outstanding
    do_reset();
    for (int i = 0; i < 30 && !(acc_now && last_acc == 32'hC); i++) tick();
    chk("t3_reach_0xc", last_acc, 32'hC);
    lat = 4;
    for (int i = 0; i < 20 && !(acc_now && last_acc == 32'h14); i++) tick();
    chk("t3_reach_0x14", last_acc, 32'h14);
    chk("t3_two_outstanding", 32'(pend.size()), 32'd2);
    i_redirect = 1'b1; i_redirect_pc = 32'h103;
    tick();
    chk("t3_no_req_on_redirect", 32'(s_req), 32'd0);
    i_redirect = 1'b0; lat = 1;
    dlv_now = 1'b0;
    for (int i = 0; i < 30 && !dlv_now; i++) tick();
    chk("t3_first_pc_after_redirect", dlv_pc, 32'h100);

    // 4: redirect coinciding with a response and a pop
    for (int i = 0; i < 20; i++) begin
      if (i_imem_rvalid && o_id_valid) break;
      tick();
    end
    chk("t4_setup", 32'(i_imem_rvalid && o_id_valid), 32'd1);
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    tick();
    chk("t4_no_valid_after_redirect", 32'(s_valid), 32'd0);
    dlv_now = 1'b0;
    for (int i = 0; i < 30 && !dlv_now; i++) tick();
    chk("t4_first_pc_after_redirect", dlv_pc, 32'h200);

    // 5: alternating grant, 3-cycle memory latency
    gnt_mode = 1; lat = 3; n_dlv = 0;
    repeat (40) tick();
    chk("t5_progress", 32'(n_dlv >= 8), 32'd1);

    // 6: PC wrap, and bypass timing on an empty queue
    gnt_mode = 2; i_imem_gnt = 1'b0;
    repeat (6) tick();
    chk("t6_idle_pending", 32'(pend.size()), 32'd0);
    chk("t6_idle_valid", 32'(s_valid), 32'd0);
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFD;
    tick();
    i_redirect = 1'b0; gnt_mode = 0; i_imem_gnt = 1'b1; lat = 1;
    tick();
    chk("t6_wrap_base", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_rvalid_cycle", 32'(s_rvalid), 32'd1);
    chk("t6_wrap_addr", s_addr, 32'h0);
    chk("t6_valid_with_rvalid", 32'(s_valid), 32'(BYP));
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
